// File: rtl/eyeriss_pe_ctrl_if.sv
// Handshake and strobe bundle between a PE array controller and one Eyeriss PE.
// master: the upstream side that requests jobs and supplies data words.
// slave : the PE controller itself.
interface eyeriss_pe_ctrl_if;
    logic       start;
    logic [3:0] cfg_len;
    logic [3:0] cfg_npsum;
    logic       in_valid;
    logic       in_ready;
    logic       psum_in_valid;
    logic       psum_in_ready;
    logic [1:0] mode;
    logic       map_en;
    logic       fil_en;
    logic       regs_en;
    logic       rst_accm;
    logic       p_en_delay;
    logic [3:0] map_iterator;
    logic [3:0] filter_iterator;
    logic [3:0] psum_iterator;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, cfg_len, cfg_npsum, in_valid, psum_in_valid,
        input  in_ready, psum_in_ready, mode, map_en, fil_en, regs_en, rst_accm,
               p_en_delay, map_iterator, filter_iterator, psum_iterator,
               out_valid, busy, done, err
    );

    modport slave (
        input  start, cfg_len, cfg_npsum, in_valid, psum_in_valid,
        output in_ready, psum_in_ready, mode, map_en, fil_en, regs_en, rst_accm,
               p_en_delay, map_iterator, filter_iterator, psum_iterator,
               out_valid, busy, done, err
    );
endinterface

// File: rtl/eyeriss_pe_ctrl.sv
// Eyeriss PE sequencer: loads ifmap/filter words, runs the 1-D convolution
// multiply schedule with RAW bubbles, drains the MAC pipeline, accumulates
// upstream psums and reports completion.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; config legality checked here
// S_LOAD  | accepting L+P-1 map words (first L also write the filter)
// S_MULT  | issuing L*P MACs, tap outer / psum inner, bubbles if P<=lat
// S_DRAIN | letting the last MULT results retire through the pipeline
// S_ACCU  | adding one upstream psum per psum index, then pipeline wait
// S_FIN   | one-cycle done pulse
module eyeriss_pe_ctrl #(
    parameter int PIPE_LAT   = 3,
    parameter int SPAD_DEPTH = 12
) (
    input  logic CLK,
    input  logic clr_,
    eyeriss_pe_ctrl_if.slave pe
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MULT, S_DRAIN, S_ACCU, S_FIN
    } state_t;

    localparam logic [4:0] LAT5     = 5'(PIPE_LAT);
    localparam logic [3:0] LAT4     = 4'(PIPE_LAT);
    localparam logic [4:0] DEPTH_P1 = 5'(SPAD_DEPTH + 1);

    state_t state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [3:0] npsum_q, npsum_d;
    logic [3:0] lcnt_q, lcnt_d;
    logic [3:0] k_q, k_d;
    logic [3:0] p_q, p_d;
    logic [3:0] bub_q, bub_d;
    logic [3:0] tmr_q, tmr_d;
    logic       err_q, err_d;
    logic [PIPE_LAT-1:0] pdly_q;
    logic [PIPE_LAT-1:0] odly_q;

    logic       issue, acc_issue;
    logic [1:0] mode_c;
    logic       in_ready_c, psum_in_ready_c, map_en_c, fil_en_c, rst_accm_c;
    logic [3:0] map_it_c, fil_it_c, psum_it_c;
    logic [4:0] cfg_sum;
    logic       cfg_ok, need_bub;
    logic [3:0] m_last, k_last, p_last, bub_n;

    // Next-state, counter updates and per-state strobes.
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        npsum_d         = npsum_q;
        lcnt_d          = lcnt_q;
        k_d             = k_q;
        p_d             = p_q;
        bub_d           = bub_q;
        tmr_d           = tmr_q;
        err_d           = 1'b0;
        issue           = 1'b0;
        acc_issue       = 1'b0;
        mode_c          = 2'b00;
        in_ready_c      = 1'b0;
        psum_in_ready_c = 1'b0;
        map_en_c        = 1'b0;
        fil_en_c        = 1'b0;
        rst_accm_c      = 1'b0;
        map_it_c        = 4'd0;
        fil_it_c        = 4'd0;
        psum_it_c       = 4'd0;

        cfg_sum  = {1'b0, pe.cfg_len} + {1'b0, pe.cfg_npsum};
        cfg_ok   = (pe.cfg_len != 4'd0) && (pe.cfg_npsum != 4'd0) && (cfg_sum <= DEPTH_P1);
        m_last   = len_q + npsum_q - 4'd2;
        k_last   = len_q - 4'd1;
        p_last   = npsum_q - 4'd1;
        // A psum slot is revisited every P cycles; if that is within the
        // MAC latency, pad each tap row so the revisit lands at lat+1.
        need_bub = ({1'b0, npsum_q} <= LAT5);
        bub_n    = 4'(LAT5 + 5'd1 - {1'b0, npsum_q});

        case (state_q)
            S_IDLE: begin
                if (pe.start) begin
                    if (cfg_ok) begin
                        len_d   = pe.cfg_len;
                        npsum_d = pe.cfg_npsum;
                        lcnt_d  = 4'd0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                mode_c     = 2'b01;
                in_ready_c = 1'b1;
                map_it_c   = lcnt_q;
                fil_it_c   = lcnt_q;
                if (pe.in_valid) begin
                    map_en_c = 1'b1;
                    fil_en_c = (lcnt_q < len_q);
                    if (lcnt_q == m_last) begin
                        state_d = S_MULT;
                        k_d     = 4'd0;
                        p_d     = 4'd0;
                        bub_d   = 4'd0;
                    end else begin
                        lcnt_d = lcnt_q + 4'd1;
                    end
                end
            end
            S_MULT: begin
                mode_c    = 2'b10;
                fil_it_c  = k_q;
                map_it_c  = p_q + k_q;
                psum_it_c = p_q;
                if (bub_q != 4'd0) begin
                    // Iterators stay on the last issued op until the final bubble.
                    bub_d = bub_q - 4'd1;
                    if (bub_q == 4'd1) begin
                        k_d = k_q + 4'd1;
                        p_d = 4'd0;
                    end
                end else begin
                    issue      = 1'b1;
                    rst_accm_c = (k_q != 4'd0);
                    if (p_q != p_last) begin
                        p_d = p_q + 4'd1;
                    end else if (k_q == k_last) begin
                        state_d = S_DRAIN;
                        tmr_d   = LAT4;
                    end else if (need_bub) begin
                        bub_d = bub_n;
                    end else begin
                        k_d = k_q + 4'd1;
                        p_d = 4'd0;
                    end
                end
            end
            S_DRAIN: begin
                mode_c = 2'b10;
                if (tmr_q == 4'd1) begin
                    state_d = S_ACCU;
                    p_d     = 4'd0;
                    tmr_d   = 4'd0;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_ACCU: begin
                mode_c    = 2'b11;
                psum_it_c = p_q;
                if (tmr_q == 4'd0) begin
                    psum_in_ready_c = 1'b1;
                    if (pe.psum_in_valid) begin
                        issue      = 1'b1;
                        acc_issue  = 1'b1;
                        rst_accm_c = 1'b1;
                        if (p_q == p_last) begin
                            tmr_d = LAT4;
                        end else begin
                            p_d = p_q + 4'd1;
                        end
                    end
                end else if (tmr_q == 4'd1) begin
                    state_d = S_FIN;
                    tmr_d   = 4'd0;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, latched config and the issue delay lines.
    always_ff @(posedge CLK) begin
        if (!clr_) begin
            state_q <= S_IDLE;
            len_q   <= 4'd0;
            npsum_q <= 4'd0;
            lcnt_q  <= 4'd0;
            k_q     <= 4'd0;
            p_q     <= 4'd0;
            bub_q   <= 4'd0;
            tmr_q   <= 4'd0;
            err_q   <= 1'b0;
            pdly_q  <= '0;
            odly_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            npsum_q <= npsum_d;
            lcnt_q  <= lcnt_d;
            k_q     <= k_d;
            p_q     <= p_d;
            bub_q   <= bub_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            pdly_q  <= PIPE_LAT'({pdly_q, issue});
            odly_q  <= PIPE_LAT'({odly_q, acc_issue});
        end
    end

    assign pe.mode            = mode_c;
    assign pe.in_ready        = in_ready_c;
    assign pe.psum_in_ready   = psum_in_ready_c;
    assign pe.map_en          = map_en_c;
    assign pe.fil_en          = fil_en_c;
    assign pe.regs_en         = issue;
    assign pe.rst_accm        = rst_accm_c;
    assign pe.map_iterator    = map_it_c;
    assign pe.filter_iterator = fil_it_c;
    assign pe.psum_iterator   = psum_it_c;
    assign pe.p_en_delay      = pdly_q[PIPE_LAT-1];
    assign pe.out_valid       = odly_q[PIPE_LAT-1];
    assign pe.busy            = (state_q != S_IDLE);
    assign pe.done            = (state_q == S_FIN);
    assign pe.err             = err_q;

endmodule

// File: tb/tb_eyeriss_pe_ctrl.sv
// Directed bench for eyeriss_pe_ctrl: expected load words, MULT schedule
// slots and ACCU psum indices are queued per job, pipeline strobes are
// queued with their due cycle, and everything is popped as the PE emits it.
module tb_eyeriss_pe_ctrl;
    localparam int PL    = 3;
    localparam int DEPTH = 12;

    logic CLK = 1'b0;
    logic clr_;

    eyeriss_pe_ctrl_if pe_if ();

    eyeriss_pe_ctrl #(.PIPE_LAT(PL), .SPAD_DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .clr_ (clr_),
        .pe   (pe_if.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int e;
    } exp_t;

    exp_t ld_q[$];
    exp_t mu_q[$];
    int   ac_q[$];
    int   pen_q[$];
    int   ov_q[$];

    int n_vec = 0;
    int n_mis = 0;
    int cyc_n = 0;
    int mult_base = 0;
    int last_acc_cyc = 0;
    int done_seen = 0;
    int err_seen = 0;
    bit acc_issue_now;
    bit pready_now;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic int out_vec();
        return int'({pe_if.mode, pe_if.map_en, pe_if.fil_en, pe_if.regs_en, pe_if.rst_accm,
                     pe_if.p_en_delay, pe_if.map_iterator, pe_if.filter_iterator,
                     pe_if.psum_iterator, pe_if.out_valid, pe_if.busy, pe_if.done,
                     pe_if.err, pe_if.in_ready, pe_if.psum_in_ready});
    endfunction

    // Called once per clock at the falling edge.
    task automatic monitor();
        exp_t e;
        bit   due;
        acc_issue_now = 1'b0;
        pready_now    = pe_if.psum_in_ready;

        if (pe_if.map_en === 1'b1) begin
            if (ld_q.size() == 0) begin
                check("map_en_unexpected", int'(pe_if.map_en), 0);
            end else begin
                e = ld_q.pop_front();
                check("load_map_it", int'(pe_if.map_iterator), e.a);
                check("load_fil_it", int'(pe_if.filter_iterator), e.b);
                check("load_fil_en", int'(pe_if.fil_en), e.c);
            end
        end else if (pe_if.fil_en === 1'b1) begin
            check("fil_en_without_map_en", int'(pe_if.fil_en), 0);
        end

        if (pe_if.regs_en === 1'b1) begin
            pen_q.push_back(cyc_n + PL);
            if (pe_if.mode == 2'b10) begin
                if (mu_q.size() == 0) begin
                    check("mult_issue_unexpected", int'(pe_if.regs_en), 0);
                end else begin
                    e = mu_q.pop_front();
                    if (e.e == 0) mult_base = cyc_n;
                    check("mult_fil_it", int'(pe_if.filter_iterator), e.a);
                    check("mult_map_it", int'(pe_if.map_iterator), e.b);
                    check("mult_psum_it", int'(pe_if.psum_iterator), e.c);
                    check("mult_rst_accm", int'(pe_if.rst_accm), e.d);
                    check("mult_slot", cyc_n - mult_base, e.e);
                end
            end else if (pe_if.mode == 2'b11) begin
                acc_issue_now = 1'b1;
                last_acc_cyc  = cyc_n;
                ov_q.push_back(cyc_n + PL);
                if (ac_q.size() == 0) begin
                    check("accu_issue_unexpected", int'(pe_if.regs_en), 0);
                end else begin
                    check("accu_psum_it", int'(pe_if.psum_iterator), ac_q.pop_front());
                    check("accu_rst_accm", int'(pe_if.rst_accm), 1);
                    check("accu_needs_valid", int'(pe_if.psum_in_valid), 1);
                end
            end else begin
                check("issue_mode", int'(pe_if.mode), 2);
            end
        end

        due = (pen_q.size() > 0) && (pen_q[0] == cyc_n);
        check("p_en_delay", int'(pe_if.p_en_delay), int'(due));
        if (due) void'(pen_q.pop_front());

        due = (ov_q.size() > 0) && (ov_q[0] == cyc_n);
        check("out_valid", int'(pe_if.out_valid), int'(due));
        if (due) void'(ov_q.pop_front());

        if (pe_if.done === 1'b1) begin
            done_seen++;
            check("done_time", cyc_n, last_acc_cyc + PL + 1);
        end
        if (pe_if.err === 1'b1) err_seen++;
        cyc_n++;
    endtask

    task automatic cyc();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
    endtask

    task automatic prime(input int L, input int P);
        exp_t e;
        int   s;
        s = (P > PL) ? P : PL + 1;
        for (int c = 0; c < L + P - 1; c++) begin
            e.a = c; e.b = c; e.c = int'(c < L); e.d = 0; e.e = 0;
            ld_q.push_back(e);
        end
        for (int k = 0; k < L; k++) begin
            for (int p = 0; p < P; p++) begin
                e.a = k; e.b = p + k; e.c = p; e.d = int'(k != 0); e.e = k * s + p;
                mu_q.push_back(e);
            end
        end
        for (int p = 0; p < P; p++) ac_q.push_back(p);
        done_seen = 0;
        err_seen  = 0;
    endtask

    task automatic run_job(input int L, input int P, input bit gap, input int pdel, input bit poke);
        int pwait;
        bit fin;
        prime(L, P);
        pwait = 0;
        fin   = 1'b0;
        pe_if.start         = 1'b1;
        pe_if.cfg_len       = 4'(L);
        pe_if.cfg_npsum     = 4'(P);
        pe_if.in_valid      = 1'b1;
        pe_if.psum_in_valid = 1'b1;
        cyc();
        pe_if.start = 1'b0;
        for (int i = 0; i < 600 && !fin; i++) begin
            if (i == 0) check("busy_running", int'(pe_if.busy), 1);
            pe_if.in_valid      = gap ? i[0] : 1'b1;
            pe_if.psum_in_valid = (pwait >= pdel);
            if (poke && i == 2) begin
                pe_if.start     = 1'b1;
                pe_if.cfg_len   = 4'd1;
                pe_if.cfg_npsum = 4'd1;
            end else if (poke && i == 3) begin
                pe_if.start     = 1'b0;
                pe_if.cfg_len   = 4'(L);
                pe_if.cfg_npsum = 4'(P);
            end
            cyc();
            if (acc_issue_now) pwait = 0;
            else if (pready_now) pwait++;
            if (done_seen > 0) fin = 1'b1;
        end
        check("job_done_reached", int'(fin), 1);
        check("idle_after_done_busy", int'(pe_if.busy), 0);
        check("idle_after_done_mode", int'(pe_if.mode), 0);
        check("done_count", done_seen, 1);
        check("err_during_job", err_seen, 0);
        check("load_words_left", ld_q.size(), 0);
        check("mult_ops_left", mu_q.size(), 0);
        check("accu_ops_left", ac_q.size(), 0);
        check("p_en_pending", pen_q.size(), 0);
        check("out_valid_pending", ov_q.size(), 0);
    endtask

    task automatic illegal(input int L, input int P);
        err_seen = 0;
        pe_if.start     = 1'b1;
        pe_if.cfg_len   = 4'(L);
        pe_if.cfg_npsum = 4'(P);
        cyc();
        pe_if.start = 1'b0;
        check("illegal_err_pulse", int'(pe_if.err), 1);
        check("illegal_busy", int'(pe_if.busy), 0);
        cyc();
        check("illegal_err_once", int'(pe_if.err), 0);
        check("illegal_busy_later", int'(pe_if.busy), 0);
        cyc();
        check("illegal_err_count", err_seen, 1);
    endtask

    task automatic abort_mid_mult();
        prime(3, 4);
        pe_if.start         = 1'b1;
        pe_if.cfg_len       = 4'd3;
        pe_if.cfg_npsum     = 4'd4;
        pe_if.in_valid      = 1'b1;
        pe_if.psum_in_valid = 1'b1;
        cyc();
        pe_if.start = 1'b0;
        for (int i = 0; i < 100 && mu_q.size() > 9; i++) cyc();
        check("abort_reached_mult", int'(mu_q.size() <= 9), 1);
        clr_ = 1'b0;
        cyc();
        check("abort_outputs_zero", out_vec(), 0);
        clr_ = 1'b1;
        ld_q.delete();
        mu_q.delete();
        ac_q.delete();
        pen_q.delete();
        ov_q.delete();
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("abort_quiet", out_vec(), 0);
        end
        check("abort_no_done", done_seen, 0);
        check("abort_no_err", err_seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_                = 1'b0;
        pe_if.start         = 1'b0;
        pe_if.cfg_len       = 4'd0;
        pe_if.cfg_npsum     = 4'd0;
        pe_if.in_valid      = 1'b0;
        pe_if.psum_in_valid = 1'b0;
        cyc();
        cyc();
        check("reset_outputs", out_vec(), 0);
        clr_ = 1'b1;
        cyc();

        run_job(3, 4, 1'b0, 0, 1'b0);
        run_job(2, 2, 1'b0, 0, 1'b0);
        illegal(8, 6);
        illegal(0, 4);
        run_job(3, 4, 1'b1, 5, 1'b0);
        abort_mid_mult();
        run_job(3, 4, 1'b0, 0, 1'b0);
        run_job(4, 3, 1'b0, 0, 1'b1);
        run_job(1, 1, 1'b0, 0, 1'b0);
        run_job(5, 8, 1'b1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
